// File: rtl/capi_command_arbiter_pkg.sv
// Shared CAPI definitions for the PSL command arbiter: widths, arbiter states,
// command codes and the registered command payload.
package capi_command_arbiter_pkg;

  localparam int unsigned CMD_W    = 13;
  localparam int unsigned TAG_W    = 8;
  localparam int unsigned SIZE_W   = 12;
  localparam int unsigned CREDIT_W = 9;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned RESP_W   = 8;
  localparam int unsigned ROOM_W   = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  localparam logic [CMD_W-1:0] READ_CL_NA = 13'h0A00;
  localparam logic [CMD_W-1:0] WRITE_NA   = 13'h0D00;

  typedef struct packed {
    logic [CMD_W-1:0]  command;
    logic [ADDR_W-1:0] address;
    logic [TAG_W-1:0]  tag;
    logic [SIZE_W-1:0] size;
  } cmd_t;

endpackage

// File: rtl/capi_command_arbiter_if.sv
// Requester, PSL command, PSL response and completion signals of the arbiter.
// The arbiter uses the master modport; the engines/PSL side uses slave.
interface capi_command_arbiter_if
  import capi_command_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*CMD_W-1:0]  req_command;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*SIZE_W-1:0] req_size;
  logic [NUM_REQ-1:0]        req_ready;
  logic [TAG_W-1:0]          req_tag;

  logic                      cmd_valid;
  logic [CMD_W-1:0]          cmd_command;
  logic [ADDR_W-1:0]         cmd_address;
  logic [TAG_W-1:0]          cmd_tag;
  logic [SIZE_W-1:0]         cmd_size;
  logic                      cmd_command_parity;
  logic                      cmd_address_parity;
  logic                      cmd_tag_parity;

  logic                      rsp_valid;
  logic [TAG_W-1:0]          rsp_tag;
  logic [RESP_W-1:0]         rsp_response;
  logic [CREDIT_W-1:0]       rsp_credits;

  logic [NUM_REQ-1:0]        done_valid;
  logic [TAG_W-1:0]          done_tag;
  logic [RESP_W-1:0]         done_response;

  modport master (
    input  req_valid, req_command, req_address, req_size,
    output req_ready, req_tag,
    output cmd_valid, cmd_command, cmd_address, cmd_tag, cmd_size,
    output cmd_command_parity, cmd_address_parity, cmd_tag_parity,
    input  rsp_valid, rsp_tag, rsp_response, rsp_credits,
    output done_valid, done_tag, done_response
  );

  modport slave (
    output req_valid, req_command, req_address, req_size,
    input  req_ready, req_tag,
    input  cmd_valid, cmd_command, cmd_address, cmd_tag, cmd_size,
    input  cmd_command_parity, cmd_address_parity, cmd_tag_parity,
    output rsp_valid, rsp_tag, rsp_response, rsp_credits,
    input  done_valid, done_tag, done_response
  );

endinterface

// File: rtl/capi_tag_pool.sv
// Command tag pool: outstanding bitmap, lowest-free allocation, owner table
// and detection of responses that do not match an outstanding tag.
module capi_tag_pool
  import capi_command_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned NUM_TAGS = 32,
  localparam int unsigned REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc,
  input  logic [REQ_W-1:0] alloc_owner,
  output logic             alloc_ok,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic             free_hit,
  output logic [REQ_W-1:0] free_owner,
  output logic             free_error,
  output logic             busy
);

  logic [NUM_TAGS-1:0] outstanding;
  logic [REQ_W-1:0]    owner [NUM_TAGS];
  logic                found_free;
  logic                tag_live;

  // Lowest-index free tag.
  always_comb begin
    found_free = 1'b0;
    alloc_tag  = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (!found_free && !outstanding[i]) begin
        found_free = 1'b1;
        alloc_tag  = TAG_W'(i);
      end
    end
  end

  // Out-of-range tags never match, so they fall through to the error path.
  always_comb begin
    tag_live   = 1'b0;
    free_owner = '0;
    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (free_tag == TAG_W'(i)) begin
        tag_live   = outstanding[i];
        free_owner = owner[i];
      end
    end
  end

  assign alloc_ok   = found_free;
  assign free_hit   = free_valid && tag_live;
  assign free_error = free_valid && !tag_live;
  assign busy       = |outstanding;

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        owner[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        if (alloc && alloc_tag == TAG_W'(i)) begin
          outstanding[i] <= 1'b1;
          owner[i]       <= alloc_owner;
        end else if (free_hit && free_tag == TAG_W'(i)) begin
          outstanding[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/capi_command_arbiter.sv
// Shares the PSL command port between NUM_REQ engines: round-robin grant,
// tag allocation, credit accounting and response routing back to tag owners.
module capi_command_arbiter
  import capi_command_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned NUM_TAGS = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ROOM_W-1:0]     room,
  capi_command_arbiter_if.master bus,
  output logic                  busy,
  output logic                  tag_error
);

  localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          state;
  logic [CREDIT_W-1:0] credits;
  logic [CREDIT_W:0]   credit_ret;
  logic [CREDIT_W:0]   credit_next;
  logic [REQ_W-1:0]    rr_ptr;
  logic [REQ_W-1:0]    rr_idx;
  logic [REQ_W-1:0]    winner;
  logic [REQ_W-1:0]    next_ptr;
  logic                found;
  logic                grant;
  logic                credit_ok;
  cmd_t                cmd_sel;
  cmd_t                cmd_q;
  logic                cmd_valid_q;
  logic [NUM_REQ-1:0]  done_valid_q;
  logic [TAG_W-1:0]    done_tag_q;
  logic [RESP_W-1:0]   done_resp_q;
  logic                alloc_ok;
  logic [TAG_W-1:0]    alloc_tag;
  logic                rsp_hit;
  logic                rsp_err;
  logic [REQ_W-1:0]    rsp_owner;

  // Round-robin search starting at the pointer.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    rr_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = REQ_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  // Credits are two's complement; a negative count must never grant.
  assign credit_ok = !credits[CREDIT_W-1] && (credits != '0);
  assign grant     = !reset && (state == RUN) && enable && credit_ok && alloc_ok && found;
  assign next_ptr  = REQ_W'((32'(winner) + 1) % NUM_REQ);

  assign bus.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  assign bus.req_tag   = alloc_tag;

  always_comb begin
    cmd_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == REQ_W'(i)) begin
        cmd_sel.command = bus.req_command[i*CMD_W +: CMD_W];
        cmd_sel.address = bus.req_address[i*ADDR_W +: ADDR_W];
        cmd_sel.size    = bus.req_size[i*SIZE_W +: SIZE_W];
      end
    end
    cmd_sel.tag = alloc_tag;
  end

  // Grant and credit return in the same cycle both apply.
  assign credit_ret  = bus.rsp_valid ? {bus.rsp_credits[CREDIT_W-1], bus.rsp_credits} : '0;
  assign credit_next = {credits[CREDIT_W-1], credits} - (CREDIT_W+1)'(grant) + credit_ret;

  capi_tag_pool #(
    .NUM_REQ  (NUM_REQ),
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_pool (
    .clock       (clock),
    .reset       (reset),
    .alloc       (grant),
    .alloc_owner (winner),
    .alloc_ok    (alloc_ok),
    .alloc_tag   (alloc_tag),
    .free_valid  (bus.rsp_valid),
    .free_tag    (bus.rsp_tag),
    .free_hit    (rsp_hit),
    .free_owner  (rsp_owner),
    .free_error  (rsp_err),
    .busy        (busy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= INIT;
      credits      <= '0;
      rr_ptr       <= '0;
      cmd_q        <= '0;
      cmd_valid_q  <= 1'b0;
      done_valid_q <= '0;
      done_tag_q   <= '0;
      done_resp_q  <= '0;
      tag_error    <= 1'b0;
    end else begin
      cmd_valid_q  <= grant;
      done_valid_q <= rsp_hit ? (NUM_REQ'(1) << rsp_owner) : '0;
      if (rsp_hit) begin
        done_tag_q  <= bus.rsp_tag;
        done_resp_q <= bus.rsp_response;
      end
      if (rsp_err) begin
        tag_error <= 1'b1;
      end
      case (state)
        INIT: begin
          if (enable) begin
            credits <= CREDIT_W'(room);
            state   <= RUN;
          end
        end
        RUN: begin
          credits <= credit_next[CREDIT_W-1:0];
          if (grant) begin
            rr_ptr <= next_ptr;
            cmd_q  <= cmd_sel;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign bus.cmd_valid          = cmd_valid_q;
  assign bus.cmd_command        = cmd_q.command;
  assign bus.cmd_address        = cmd_q.address;
  assign bus.cmd_tag            = cmd_q.tag;
  assign bus.cmd_size           = cmd_q.size;
  assign bus.cmd_command_parity = ~^cmd_q.command;
  assign bus.cmd_address_parity = ~^cmd_q.address;
  assign bus.cmd_tag_parity     = ~^cmd_q.tag;
  assign bus.done_valid         = done_valid_q;
  assign bus.done_tag           = done_tag_q;
  assign bus.done_response      = done_resp_q;

endmodule

// File: tb/tb_capi_command_arbiter.sv
// Vector-table bench for capi_command_arbiter with a scoreboard queue for the
// registered command and completion outputs.
module tb_capi_command_arbiter;
  import capi_command_arbiter_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned NTAGS = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] room;
  logic       busy;
  logic       tag_error;

  capi_command_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  capi_command_arbiter #(
    .NUM_REQ  (NREQ),
    .NUM_TAGS (NTAGS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .room      (room),
    .bus       (bus.master),
    .busy      (busy),
    .tag_error (tag_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] rv;
    logic       rsp_v;
    logic [7:0] rsp_tag;
    logic [8:0] rsp_cr;
    logic [7:0] rsp_code;
    logic [1:0] exp_ready;
    logic [7:0] exp_tag;
    logic [1:0] exp_done;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    int   cyc;
    cmd_t c;
  } cmd_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] v;
    logic [7:0] tag;
    logic [7:0] resp;
  } done_exp_t;

  cmd_exp_t  cq[$];
  done_exp_t dq[$];
  vec_t      va[$];
  vec_t      vb[$];
  vec_t      vc[$];
  int        total = 0;
  int        bad   = 0;
  int        cyc   = 0;
  int        drv   = 0;

  function automatic vec_t mk(input logic en, input logic [1:0] rv, input logic rsp_v,
                              input int rsp_tag, input int rsp_cr, input int rsp_code,
                              input logic [1:0] exp_ready, input int exp_tag,
                              input logic [1:0] exp_done, input logic exp_err,
                              input logic exp_busy);
    vec_t v;
    v.rst       = 1'b0;
    v.en        = en;
    v.rv        = rv;
    v.rsp_v     = rsp_v;
    v.rsp_tag   = 8'(rsp_tag);
    v.rsp_cr    = 9'(rsp_cr);
    v.rsp_code  = 8'(rsp_code);
    v.exp_ready = exp_ready;
    v.exp_tag   = 8'(exp_tag);
    v.exp_done  = exp_done;
    v.exp_err   = exp_err;
    v.exp_busy  = exp_busy;
    return v;
  endfunction

  function automatic cmd_t exp_cmd(input logic w, input logic [7:0] tag);
    cmd_t c;
    c.command = w ? WRITE_NA : READ_CL_NA;
    c.address = (w ? 64'h0000_2000_0000_0000 : 64'h0000_1000_0000_0000) | 64'(drv);
    c.tag     = tag;
    c.size    = w ? 12'd64 : 12'd128;
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_req();
    bus.req_command = {WRITE_NA, READ_CL_NA};
    bus.req_address = {64'h0000_2000_0000_0000 | 64'(drv), 64'h0000_1000_0000_0000 | 64'(drv)};
    bus.req_size    = {12'd64, 12'd128};
  endtask

  task automatic step(input vec_t v);
    cmd_exp_t  ce;
    done_exp_t de;
    reset            = v.rst;
    enable           = v.en;
    bus.req_valid    = v.rv;
    bus.rsp_valid    = v.rsp_v;
    bus.rsp_tag      = v.rsp_tag;
    bus.rsp_credits  = v.rsp_cr;
    bus.rsp_response = v.rsp_code;
    drv++;
    drive_req();
    @(negedge clock);
    cyc++;
    if (cq.size() > 0 && cq[0].cyc == cyc) begin
      ce = cq.pop_front();
      chk("cmd_valid", 64'(bus.cmd_valid), 64'd1);
      chk("cmd_command", 64'(bus.cmd_command), 64'(ce.c.command));
      chk("cmd_address", bus.cmd_address, ce.c.address);
      chk("cmd_tag", 64'(bus.cmd_tag), 64'(ce.c.tag));
      chk("cmd_size", 64'(bus.cmd_size), 64'(ce.c.size));
      chk("cmd_tag_parity", 64'(bus.cmd_tag_parity), 64'(~^ce.c.tag));
      chk("cmd_command_parity", 64'(bus.cmd_command_parity), 64'(~^ce.c.command));
      chk("cmd_address_parity", 64'(bus.cmd_address_parity), 64'(~^ce.c.address));
    end else begin
      chk("cmd_valid idle", 64'(bus.cmd_valid), 64'd0);
    end
    if (dq.size() > 0 && dq[0].cyc == cyc) begin
      de = dq.pop_front();
      chk("done_valid", 64'(bus.done_valid), 64'(de.v));
      chk("done_tag", 64'(bus.done_tag), 64'(de.tag));
      chk("done_response", 64'(bus.done_response), 64'(de.resp));
    end else begin
      chk("done_valid idle", 64'(bus.done_valid), 64'd0);
    end
    chk("req_ready", 64'(bus.req_ready), 64'(v.exp_ready));
    if (v.exp_ready != 2'b00) begin
      chk("req_tag", 64'(bus.req_tag), 64'(v.exp_tag));
      ce.cyc = cyc + 1;
      ce.c   = exp_cmd(v.exp_ready[1], v.exp_tag);
      cq.push_back(ce);
    end
    if (v.exp_done != 2'b00) begin
      de.cyc  = cyc + 1;
      de.v    = v.exp_done;
      de.tag  = v.rsp_tag;
      de.resp = v.rsp_code;
      dq.push_back(de);
    end
    chk("tag_error", 64'(tag_error), 64'(v.exp_err));
    chk("busy", 64'(busy), 64'(v.exp_busy));
    @(posedge clock);
    #1;
  endtask

  task automatic hw_reset();
    reset         = 1'b1;
    enable        = 1'b0;
    bus.req_valid = '0;
    bus.rsp_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst cmd_valid", 64'(bus.cmd_valid), 64'd0);
    chk("rst cmd_command", 64'(bus.cmd_command), 64'd0);
    chk("rst cmd_address", bus.cmd_address, 64'd0);
    chk("rst cmd_tag", 64'(bus.cmd_tag), 64'd0);
    chk("rst cmd_size", 64'(bus.cmd_size), 64'd0);
    chk("rst cmd_tag_parity", 64'(bus.cmd_tag_parity), 64'd1);
    chk("rst cmd_command_parity", 64'(bus.cmd_command_parity), 64'd1);
    chk("rst cmd_address_parity", 64'(bus.cmd_address_parity), 64'd1);
    chk("rst done_valid", 64'(bus.done_valid), 64'd0);
    chk("rst done_tag", 64'(bus.done_tag), 64'd0);
    chk("rst done_response", 64'(bus.done_response), 64'd0);
    chk("rst tag_error", 64'(tag_error), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t v;
    // Credit load, credit gating, tag error and pool exhaustion (room = 8).
    va.push_back(mk(0, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    for (int i = 0; i < 8; i++) begin
      va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b01, i, 2'b00, 0, i > 0));
    end
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
    va.push_back(mk(1, 2'b01, 1, 5, 0, 8'h00, 2'b00, 0, 2'b01, 0, 1));
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
    va.push_back(mk(1, 2'b01, 1, 2, 1, 8'h01, 2'b00, 0, 2'b01, 0, 1));
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b01, 2, 2'b00, 0, 1));
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));
    va.push_back(mk(1, 2'b00, 1, 9, 2, 8'h02, 2'b00, 0, 2'b00, 0, 1));
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b01, 5, 2'b00, 1, 1));
    va.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1));

    // Round-robin alternation and response routing (room = 64).
    vb.push_back(mk(1, 2'b11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0));
    vb.push_back(mk(1, 2'b11, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0));
    vb.push_back(mk(1, 2'b11, 0, 0, 0, 0, 2'b10, 1, 2'b00, 0, 1));
    vb.push_back(mk(1, 2'b11, 0, 0, 0, 0, 2'b01, 2, 2'b00, 0, 1));
    vb.push_back(mk(1, 2'b11, 0, 0, 0, 0, 2'b10, 3, 2'b00, 0, 1));
    vb.push_back(mk(1, 2'b10, 1, 3, 1, 8'h05, 2'b10, 4, 2'b10, 0, 1));
    vb.push_back(mk(1, 2'b10, 0, 0, 0, 0, 2'b10, 3, 2'b00, 0, 1));
    vb.push_back(mk(1, 2'b00, 1, 0, 0, 8'h0A, 2'b00, 0, 2'b01, 0, 1));
    vb.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1));

    // After a mid-op reset: room reload and simultaneous grant + credit return.
    vc.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));
    vc.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b01, 0, 2'b00, 1, 0));
    vc.push_back(mk(1, 2'b01, 1, 0, 1, 8'h00, 2'b01, 1, 2'b01, 1, 1));
    vc.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b01, 0, 2'b00, 1, 1));
    vc.push_back(mk(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1));
    vc.push_back(mk(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1));

    bus.req_valid    = '0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_tag      = '0;
    bus.rsp_credits  = '0;
    bus.rsp_response = '0;
    drive_req();
    reset  = 1'b1;
    enable = 1'b0;

    room = 8'd8;
    hw_reset();
    foreach (va[i]) step(va[i]);

    room = 8'd64;
    hw_reset();
    foreach (vb[i]) step(vb[i]);

    // One-cycle reset with tags 1..4 outstanding, then a late response.
    room = 8'd2;
    v = mk(1, 2'b11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1);
    v.rst = 1'b1;
    step(v);
    step(mk(0, 2'b00, 1, 2, 0, 8'h00, 2'b00, 0, 2'b00, 0, 0));
    step(mk(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0));

    foreach (vc[i]) step(vc[i]);

    chk("scoreboard drained", 64'(cq.size() + dq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capi_command_arbiter.md
Name: capi_command_arbiter

Overview:
- Shares the single PSL command interface between NUM_REQ work-element engines (WED fetch, stripe read, parity write, ...).
- Per cycle: picks a requester round-robin, allocates a free command tag, enforces the PSL command credit count, and drives the registered command bus.
- Routes each PSL response back to the requester that owns the tag, then returns the tag and credits to the pools.
- Sits between the work-element sequencers and the PSL command/response ports.

Parameters:
- NUM_REQ, 2, number of requesting engines (1..8).
- NUM_TAGS, 32, size of the tag pool (1..256); tags are 0..NUM_TAGS-1.

Ports:
- clock  in  1  PSL clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  job running; when low, no new grants.
- room  in  8  PSL initial command credits.
- req_valid  in  NUM_REQ  per-requester command request.
- req_command  in  NUM_REQ*13  command codes, requester i at bits [13i+:13].
- req_address  in  NUM_REQ*64  effective addresses.
- req_size  in  NUM_REQ*12  transfer sizes in bytes.
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted req_valid.
- req_tag  out  8  tag assigned to the granted requester; valid while any req_ready bit is set.
- cmd_valid  out  1  PSL command valid; one-cycle pulse per command.
- cmd_command  out  13  PSL command code.
- cmd_address  out  64  PSL effective address.
- cmd_tag  out  8  PSL command tag.
- cmd_size  out  12  PSL size.
- cmd_command_parity, cmd_address_parity, cmd_tag_parity  out  1 each  odd parity (~^field).
- rsp_valid  in  1  PSL response valid.
- rsp_tag  in  8  response tag.
- rsp_response  in  8  response code.
- rsp_credits  in  9  signed credit return.
- done_valid  out  NUM_REQ  one-hot, registered: response delivered to the tag owner.
- done_tag  out  8  tag of the delivered response.
- done_response  out  8  response code of the delivered response.
- busy  out  1  at least one tag outstanding.
- tag_error  out  1  sticky; set on a response for a free or out-of-range tag.

Behaviour:
- Reset values: cmd_valid=0, cmd_command=0, cmd_address=0, cmd_tag=0, cmd_size=0, done_valid=0, done_tag=0, done_response=0, tag_error=0, busy=0. Internal: credits=0, all tags free, round-robin pointer=0, state INIT. Parity outputs follow their fields (cmd_tag_parity=1 at reset).
- State INIT: on the first cycle with enable=1, load credits<=room and go to RUN. No grants are issued in INIT.
- State RUN, grant condition in cycle N: enable && credits>0 && free tag exists && |req_valid.
  - Winner = first requester at or after the pointer with req_valid set, wrapping modulo NUM_REQ.
  - Tag = lowest-index free tag.
  - req_ready[winner]=1 and req_tag=tag, both combinational in cycle N.
  - On the cycle N clock edge: tag marked outstanding, owner[tag]<=winner, pointer<=winner+1 (modulo NUM_REQ), cmd_* fields loaded.
  - Cycle N+1: cmd_valid=1. Maximum rate is one command per cycle.
- Credit update each cycle: credits <= credits - grant + (rsp_valid ? sign-extended rsp_credits : 0). Simultaneous grant and credit return in one cycle must both apply. credits=0 blocks grants until a return arrives.
- Response in cycle M, tag outstanding:
  - done_valid[owner]=1, done_tag, done_response driven in cycle M+1.
  - Tag freed at edge M; it may be reallocated from cycle M+1, never in cycle M.
- Response for a free tag or a tag >= NUM_TAGS: tag_error<=1, no done pulse, no tag state change; credits are still applied.
- Pool exhaustion (all NUM_TAGS outstanding): no grant until a response frees a tag.
- enable=0 in RUN: grants stop; responses, tag frees and credit updates continue.
- reset asserted mid-operation: all outstanding tags discarded, return to INIT. cmd_valid and done_valid are 0 from the next cycle; late responses after reset set tag_error.
- busy = OR of the outstanding bitmap (registered state).
- Invariant: credits never exceed the loaded room value and never go negative.

Decomposition:
- Add to the shared CAPI package:
  - width constants CMD_W=13, TAG_W=8, SIZE_W=12, CREDIT_W=9;
  - arbiter state enum {INIT, RUN};
  - command code constants (READ_CL_NA=13'h0A00, WRITE_NA=13'h0D00).
- One sub-module, capi_tag_pool: free bitmap, lowest-free priority encoder, owner table, allocate/free ports, error detect.
- Arbitration, credit counter and output registers stay in capi_command_arbiter.

Test Plan:
- Credit load: reset, room=8, enable=1, one requester issues 10 back-to-back reads with no responses -> exactly 8 cmd_valid pulses, tags 0..7, each one cycle after its grant; 9th held.
- Round-robin: NUM_REQ=2, both req_valid held, room=64 -> grants alternate 0,1,0,1; cmd_tag 0,1,2,3; cmd_tag_parity matches ~^tag.
- Response routing: requester 1 gets tag 3, response tag 3 code 0 credits +1 -> done_valid=2'b10, done_tag=3 next cycle; tag 3 reissued no earlier than the following cycle.
- Simultaneous events: credits=1, grant and response with credits +1 in the same cycle -> credits stays 1; next grant occurs.
- Exhaustion and error: NUM_TAGS=4, 4 outstanding -> no grant; response on free tag 9 -> tag_error=1, no done pulse; response tag 2 -> next grant gets tag 2.
- Mid-op reset: 3 tags outstanding, reset for 1 cycle -> busy=0, cmd_valid=0; then enable -> room reloaded, first tag 0.
